// File: rtl/majority_window_voter.sv
// -----------------------------------------------------------------------------
// majority_window_voter
//
// Sliding-window majority voter for a qualified serial bit stream. The last N
// accepted samples are held in a shift window. A running ones count follows
// the window contents, and a registered majority decision is produced for each
// accepted sample once the window has filled.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     sample qualifier; in_bit is accepted on any edge with in_valid=1
//   in_bit       sample value
//   flush        synchronous window clear (dominates in_valid)
//   out_valid    one-cycle pulse, maj/ones_count fresh for a full-window accept
//   maj          majority decision (ones_count > N/2, tie -> 0 for even N)
//   ones_count   number of ones currently in the window
//   window_full  high once N samples accepted since last reset/flush
// -----------------------------------------------------------------------------
module majority_window_voter #(
   parameter  int N  = 8,
   localparam int CW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic          in_bit,
   input  logic          flush,
   output logic          out_valid,
   output logic          maj,
   output logic [CW-1:0] ones_count,
   output logic          window_full
);

   typedef enum logic {
      FILLING = 1'b0,
      FULL    = 1'b1
   } state_t;

   state_t        state;
   logic [N-1:0]  window;
   logic [CW-1:0] fill_cnt;

   logic [CW-1:0] add_one;
   logic [CW-1:0] sub_one;
   logic [CW-1:0] ones_nxt;
   logic          fill_done;

   // Integer-division threshold: for even N a tie of N/2 ones votes 0.
   function automatic logic majority(input logic [CW-1:0] cnt);
      return cnt > CW'(N / 2);
   endfunction

   // Next ones count: the oldest sample only leaves once the window is full,
   // so the net change per accept is -1, 0 or +1 and cannot leave 0..N.
   always_comb begin
      add_one   = CW'(in_bit);
      sub_one   = (state == FULL) ? CW'(window[N-1]) : '0;
      ones_nxt  = ones_count + add_one - sub_one;
      fill_done = (fill_cnt == CW'(N - 1));
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state       <= FILLING;
         window      <= '0;
         fill_cnt    <= '0;
         ones_count  <= '0;
         maj         <= 1'b0;
         out_valid   <= 1'b0;
         window_full <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (in_valid) begin
            window     <= {window[N-2:0], in_bit};
            ones_count <= ones_nxt;
            maj        <= majority(ones_nxt);
            case (state)
               FILLING: begin
                  fill_cnt <= fill_cnt + 1'b1;
                  // The accept that completes the fill already reports.
                  if (fill_done) begin
                     state       <= FULL;
                     window_full <= 1'b1;
                     out_valid   <= 1'b1;
                  end
               end
               FULL: begin
                  out_valid <= 1'b1;
               end
               default: begin
                  state <= FILLING;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_majority_window_voter.sv
module tb_majority_window_voter;

   localparam int NA = 8;
   localparam int NB = 5;
   localparam int CA = $clog2(NA + 1);
   localparam int CB = $clog2(NB + 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b1;

   logic          a_vld = 1'b0, a_bit = 1'b0, a_flush = 1'b0;
   logic          a_ov, a_maj, a_full;
   logic [CA-1:0] a_ones;

   logic          b_vld = 1'b0, b_bit = 1'b0, b_flush = 1'b0;
   logic          b_ov, b_maj, b_full;
   logic [CB-1:0] b_ones;

   majority_window_voter #(.N(NA)) dut_a (
      .clk(clk), .rst(rst), .in_valid(a_vld), .in_bit(a_bit), .flush(a_flush),
      .out_valid(a_ov), .maj(a_maj), .ones_count(a_ones), .window_full(a_full)
   );

   majority_window_voter #(.N(NB)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_vld), .in_bit(b_bit), .flush(b_flush),
      .out_valid(b_ov), .maj(b_maj), .ones_count(b_ones), .window_full(b_full)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;
   int b_pulses = 0;

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Behavioural model: the window is simply the last N accepted samples
   // since the most recent clear; everything else is counted from it.
   bit qa[$];
   bit qb[$];
   int ea_ones = 0, eb_ones = 0;
   bit ea_maj = 0, ea_ov = 0, ea_full = 0;
   bit eb_maj = 0, eb_ov = 0, eb_full = 0;

   always @(posedge clk) begin
      if (rst || a_flush) begin
         qa.delete();
         ea_ones = 0; ea_maj = 0; ea_ov = 0; ea_full = 0;
      end else begin
         ea_ov = 0;
         if (a_vld) begin
            qa.push_back(a_bit);
            if (qa.size() > NA) void'(qa.pop_front());
            ea_ones = 0;
            foreach (qa[i]) ea_ones += qa[i];
            ea_maj  = (ea_ones > NA / 2);
            ea_full = (qa.size() == NA);
            ea_ov   = ea_full;
         end
      end
      if (rst || b_flush) begin
         qb.delete();
         eb_ones = 0; eb_maj = 0; eb_ov = 0; eb_full = 0;
      end else begin
         eb_ov = 0;
         if (b_vld) begin
            qb.push_back(b_bit);
            if (qb.size() > NB) void'(qb.pop_front());
            eb_ones = 0;
            foreach (qb[i]) eb_ones += qb[i];
            eb_maj  = (eb_ones > NB / 2);
            eb_full = (qb.size() == NB);
            eb_ov   = eb_full;
         end
      end
   end

   // Per-cycle comparison against the model, plus counter range checks.
   always @(posedge clk) begin
      #1;
      if (chk_en) begin
         check("a_out_valid",   a_ov,   ea_ov);
         check("a_maj",         a_maj,  ea_maj);
         check("a_ones_count",  a_ones, ea_ones);
         check("a_window_full", a_full, ea_full);
         check("a_ones_le_n",   (a_ones <= NA), 1);
         check("b_out_valid",   b_ov,   eb_ov);
         check("b_maj",         b_maj,  eb_maj);
         check("b_ones_count",  b_ones, eb_ones);
         check("b_window_full", b_full, eb_full);
         check("b_ones_le_n",   (b_ones <= NB), 1);
         if (b_ov) b_pulses++;
      end
   end

   task automatic tick_a(input logic v, input logic b, input logic f);
      @(negedge clk);
      a_vld = v; a_bit = b; a_flush = f;
      @(posedge clk);
      #2;
   endtask

   task automatic tick_b(input logic v, input logic b);
      @(negedge clk);
      b_vld = v; b_bit = b; b_flush = 1'b0;
      @(posedge clk);
      #2;
   endtask

   task automatic chk_a(input string nm, input int ov, input int ones, input int mj, input int full);
      check({nm, "_ov"},   a_ov,   ov);
      check({nm, "_ones"}, a_ones, ones);
      check({nm, "_maj"},  a_maj,  mj);
      check({nm, "_full"}, a_full, full);
   endtask

   int fill_seq[8] = '{1, 1, 1, 1, 1, 0, 0, 0};
   int b_seq[5]    = '{1, 0, 1, 1, 0};
   int hold_ones;

   initial begin
      // Reset for two cycles, then idle.
      @(posedge clk);
      #2;
      chk_en = 1'b1;
      tick_a(0, 0, 0);
      chk_a("reset", 0, 0, 0, 0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #2;
      for (int i = 0; i < 5; i++) begin
         tick_a(0, 0, 0);
         chk_a("idle", 0, 0, 0, 0);
      end

      // Fill N=8 with 1,1,1,1,1,0,0,0.
      for (int i = 0; i < 8; i++) begin
         tick_a(1, fill_seq[i][0], 0);
         if (i < 7) check("fill_no_ov", a_ov, 0);
      end
      chk_a("fill_done", 1, 5, 1, 1);

      // Slide: 0 then 1,1,1 each evict a 1 -> tie at 4.
      tick_a(1, 0, 0);
      chk_a("slide0", 1, 4, 0, 1);
      for (int i = 0; i < 3; i++) begin
         tick_a(1, 1, 0);
         chk_a("slide1", 1, 4, 0, 1);
      end

      // Idle cycle holds values and drops out_valid.
      tick_a(0, 0, 0);
      chk_a("hold", 0, 4, 0, 1);

      // 20 ones: saturates at 8.
      for (int i = 1; i <= 20; i++) begin
         tick_a(1, 1, 0);
         if (i >= 8) chk_a("sat", 1, 8, 1, 1);
      end
      // 20 zeros: reaches 0 at the 8th and holds.
      for (int i = 1; i <= 20; i++) begin
         tick_a(1, 0, 0);
         hold_ones = (i >= 8) ? 0 : 8 - i;
         check("drain_ones", a_ones, hold_ones);
         check("drain_ov", a_ov, 1);
      end

      // Build ones_count=6, then flush colliding with an accept.
      for (int i = 0; i < 6; i++) tick_a(1, 1, 0);
      chk_a("pre_flush", 1, 6, 1, 1);
      tick_a(1, 1, 1);
      chk_a("flush", 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) begin
         tick_a(1, 1, 0);
         check("refill_no_ov", a_ov, 0);
      end
      tick_a(1, 1, 0);
      chk_a("refill_done", 1, 8, 1, 1);

      // Mid-stream reset beats flush and in_valid.
      @(negedge clk) rst = 1'b1;
      tick_a(1, 1, 1);
      chk_a("mid_reset", 0, 0, 0, 0);
      @(negedge clk) rst = 1'b0;
      tick_a(0, 0, 0);

      // N=5 with gaps: single pulse after the 5th accept.
      b_pulses = 0;
      for (int i = 0; i < 5; i++) begin
         int gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) tick_b(0, 0);
         tick_b(1, b_seq[i][0]);
         if (i < 4) check("b_fill_no_ov", b_ov, 0);
      end
      check("b_done_ov", b_ov, 1);
      check("b_done_ones", b_ones, 3);
      check("b_done_maj", b_maj, 1);
      check("b_done_full", b_full, 1);
      for (int i = 0; i < 3; i++) tick_b(0, 0);
      check("b_pulse_count", b_pulses, 1);

      // Random traffic on both instances, checked against the model.
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         a_vld   = ($urandom_range(0, 9) < 7);
         a_bit   = 1'($urandom_range(0, 1));
         a_flush = ($urandom_range(0, 99) == 0);
         b_vld   = ($urandom_range(0, 9) < 6);
         b_bit   = 1'($urandom_range(0, 1));
         b_flush = ($urandom_range(0, 149) == 0);
         rst     = ($urandom_range(0, 999) == 0);
      end
      @(negedge clk);
      a_vld = 0; b_vld = 0; a_flush = 0; b_flush = 0; rst = 0;
      repeat (3) @(posedge clk);
      #3;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/majority_window_voter.md
Name: majority_window_voter

Overview:
- Sequential front end for the team's majority-gate logic.
- Accepts a serial stream of qualified bits and holds the most recent N samples in a shift window.
- Keeps a running count of ones and emits a registered majority decision for each accepted sample once the window has filled.
- Intended use: de-glitching noisy single-bit inputs (sensor and line voting) before downstream control logic.

Parameters:
- N, 8, window length in samples; legal range 3..64.
- CW, $clog2(N+1), width of the ones counter. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies in_bit; the sample is accepted on any rising edge where in_valid=1.
- in_bit  input  1  sample value.
- flush  input  1  synchronous window clear; leaves configuration untouched.
- out_valid  output  1  one-cycle pulse: maj and ones_count are fresh this cycle.
- maj  output  1  majority decision over the current window.
- ones_count  output  CW  number of ones currently in the window.
- window_full  output  1  high once N samples have been accepted since the last reset or flush.

Behaviour:
- Interface is fixed: one clock; reset is synchronous and active-high; ports are named clk and rst.
- Reset values: all outputs 0; window register all 0; fill counter 0; state FILLING.
- State machine, two states:
  - FILLING: fill counter < N. Each accepted sample increments the fill counter. The accept that brings it to N moves the state to FULL.
  - FULL: stays FULL until rst or flush.
- Window: on accept, shift left and insert in_bit at bit 0. The oldest sample is window[N-1].
- Counter update on accept:
  - FILLING: ones_count += in_bit.
  - FULL: ones_count += in_bit − window[N-1], using the pre-shift value.
  - Net change is −1, 0 or +1. The counter never exceeds N and never underflows; the bench asserts both.
- Decision: maj = (next ones_count > N/2), using integer division.
  - Odd N: strict majority.
  - Even N: a tie (N/2 ones) gives maj=0.
  - Must match the combinational majority gate for the same N and window contents.
- out_valid:
  - Registered; asserts exactly one cycle after every accept for which the post-accept fill count equals N. This includes the accept that completes the fill.
  - Latency: sample at edge k, result visible after edge k+1.
  - No pulse while FILLING.
- Output hold: maj and ones_count hold their values between accepts. ones_count updates during FILLING; maj also updates but carries no meaning until out_valid.
- window_full: registered; equals (state == FULL).
- Flush:
  - Next edge clears the window, ones_count, maj, fill counter and window_full; state returns to FILLING; out_valid=0.
  - flush has priority over a simultaneous in_valid; that sample is dropped.
- Reset mid-stream: identical effect to flush. Reset has priority over flush and over in_valid.
- in_valid=0: no state change; out_valid=0 on the next cycle.
- Back-to-back accepts are allowed every cycle; throughput is 1 sample per clk. There is no backpressure.
- Inputs are sampled only at the clock edge. No combinational path exists from any input to any output.

Test Plan:
- Reset/idle: assert rst for 2 cycles, then idle 5 cycles → maj=0, ones_count=0, out_valid=0, window_full=0 throughout.
- Fill, N=8: feed 1,1,1,1,1,0,0,0 on consecutive cycles → no out_valid for the first 7 accepts. The cycle after the 8th accept: out_valid=1, ones_count=5, maj=1, window_full=1.
- Slide and even-N tie: continuing from the fill case, feed 0 → oldest 1 leaves, ones_count=4, maj=0 (tie). Then feed 1 → oldest 1 leaves, ones_count=4, maj=0. Then feed 1,1 → ones_count=4 (evictions are 1,1), maj=0.
- Saturation/underflow: 20 consecutive ones → ones_count stays 8 and maj=1 from the 8th accept on. Then 20 zeros → ones_count reaches 0 exactly at the 8th zero and holds, with no wrap.
- Flush collision: when window is full with ones_count=6, assert flush and in_valid=1 (in_bit=1) in the same cycle → next cycle ones_count=0, window_full=0, out_valid=0. The following 7 accepts produce no out_valid.
- Gapped input/odd N: with N=5, feed 1,0,1,1,0 with random idle cycles between accepts → out_valid pulses once, one cycle after the 5th accept, with ones_count=3 and maj=1. Compare against a behavioral model over 10k random samples.
